apb_rr_arbiter: RTL
===================

# apb_rr_arbiter

Two-master APB arbiter that shares a single downstream APB bus, which feeds the peripheral decoder, between the AXI-to-APB bridge (master 0) and a second APB master such as debug or DMA (master 1). It arbitrates round-robin per transfer and regenerates a clean setup/access sequence downstream. It returns the completion to the granted master one cycle after the slave responds, and closes hung transfers with a programmable timeout.

## Interface
Parameters:
- TIMEOUT, 16'd1024: maximum access-phase cycles before a forced SLVERR completion; 0 disables the timeout.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- m0_psel, m0_penable, m0_pwrite  in  1 each  master 0 APB controls.
- m0_paddr  in  32  master 0 address.
- m0_pstrb  in  4  master 0 write strobes.
- m0_pwdata  in  32  master 0 write data.
- m0_prdata  out  32  master 0 read data.
- m0_pslverr  out  1  master 0 error response.
- m0_pready  out  1  master 0 completion.
- m1_*  same set as m0_*  master 1.
- psel, penable, pwrite  out  1 each  downstream APB controls.
- paddr  out  32  downstream address.
- pstrb  out  4  downstream write strobes.
- pwdata  out  32  downstream write data.
- prdata  in  32  downstream read data.
- pslverr  in  1  downstream error response.
- pready  in  1  downstream ready.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - A request is mX_psel=1, with penable ignored.
  - If any request is present, the picker chooses the grant, the FSM moves to SETUP, and the following are captured into output registers: paddr, pwrite, pstrb and pwdata from the granted master.
  - Round-robin rule: when both masters request, the master that was not granted last wins; a sole requester always wins.
  - last_grant resets to 1, so master 0 wins the first tie.
- SETUP: psel=1, penable=0 for exactly one cycle, then the FSM moves to ACCESS. The timeout counter clears.
- ACCESS:
  - psel=1, penable=1.
  - On pready=1 the following are latched and the FSM moves to RESP: prdata into rdata_q and pslverr into err_q.
  - Otherwise the counter increments. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without pready, the FSM moves to RESP with rdata_q=0 and err_q=1.
- RESP:
  - psel=0 and penable=0 downstream.
  - The granted master sees mX_pready=1, mX_prdata=rdata_q and mX_pslverr=err_q for exactly one cycle.
  - last_grant is updated and the FSM returns to IDLE.
- Non-granted master, and any master outside RESP: mX_pready=0, mX_pslverr=0, mX_prdata=0. A waiting master stalls in its access phase with no side effects.
- Granted master dropping psel before RESP is a protocol violation. The downstream transfer still completes and the pready pulse is still issued.
- Upstream address and data are not observed after capture, so downstream signals are stable for the whole transfer by construction.

## Timing
- Reset: all outputs are 0, the FSM is in IDLE, last_grant=1, and rdata_q, err_q and the counter are 0.
- Reset asserted mid-transfer: all outputs go to 0 immediately (asynchronous), and no completion is issued to either master.
- Latency for a request seen in IDLE at cycle N:
  - SETUP at N+1.
  - ACCESS from N+2.
  - Slave pready at cycle A gives mX_pready at A+1.
  - IDLE at A+2.
- A zero-wait slave gives 4 cycles per transfer.
- Back-to-back: a new request can be sampled in the IDLE cycle immediately after RESP. The completed master's new setup phase competes under round-robin.
- Timeout: the forced completion leaves ACCESS after exactly TIMEOUT cycles in ACCESS.
- Counter width is 16 bits and saturates. With TIMEOUT=0 the counter never forces completion.
- pready and pslverr are sampled only while in ACCESS. prdata is latched only on the pready cycle.

## Structure
- apb_pkg holds:
  - the state enum typedef for IDLE, SETUP, ACCESS, RESP;
  - the `APB_TO_W = 16` constant;
  - the grant encoding constants GNT_M0 = 1'b0 and GNT_M1 = 1'b1.
- Sub-module rr_arb2 is the combinational 2-way round-robin picker. Its inputs are req[1:0] and last_grant; its outputs are gnt and gnt_valid. It is reused by future arbiters.
- The top level holds the FSM, the capture registers, the response latches and the timeout counter.

## Test plan
- Single read: m0 reads 0x1000_0004 with a zero-wait slave and prdata=0xDEAD_BEEF.
  - Downstream shows psel at N+1 and penable at N+2.
  - m0_pready=1 with m0_prdata=0xDEAD_BEEF at N+3.
  - m1_pready stays 0.
- Simultaneous requests after reset: m0 and m1 both assert psel in the same cycle.
  - m0 is granted first, then m1.
  - A repeated tie alternates grants m0, m1, m0, m1 over 4 transfers.
- Wait-state write: m1 writes 0x55AA_1234 with pstrb=4'b0011, and the slave holds pready=0 for 5 ACCESS cycles.
  - Downstream address, data and strobes stay constant.
  - m1_pready pulses exactly once, 1 cycle after pready.
- Slave error: the slave returns pslverr=1 on m0's read. m0_pslverr=1 in the pready cycle. The next transfer returns pslverr=0.
- Timeout, with TIMEOUT=8 and a slave that never asserts pready:
  - After 8 ACCESS cycles, psel drops.
  - m0_pready=1 with m0_pslverr=1 and m0_prdata=0.
  - A queued m1 request is granted next.
- Reset mid-ACCESS: aresetn is pulled low.
  - psel and penable go to 0 immediately, with no mX_pready pulse.
  - After release, the first tie goes to m0.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB round-robin arbiter
package apb_pkg;

  localparam int APB_TO_W = 16;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
  import apb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt = ~last_grant;
    end else if (req[1]) begin
      gnt = GNT_M1;
    end else begin
      gnt = GNT_M0;
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - two-master APB arbiter sharing one downstream bus
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter logic [APB_TO_W-1:0] TIMEOUT = 16'd1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        m0_psel,
  input  logic        m0_penable,
  input  logic        m0_pwrite,
  input  logic [31:0] m0_paddr,
  input  logic [3:0]  m0_pstrb,
  input  logic [31:0] m0_pwdata,
  output logic [31:0] m0_prdata,
  output logic        m0_pslverr,
  output logic        m0_pready,
  input  logic        m1_psel,
  input  logic        m1_penable,
  input  logic        m1_pwrite,
  input  logic [31:0] m1_paddr,
  input  logic [3:0]  m1_pstrb,
  input  logic [31:0] m1_pwdata,
  output logic [31:0] m1_prdata,
  output logic        m1_pslverr,
  output logic        m1_pready,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [3:0]  pstrb,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pslverr,
  input  logic        pready
);

  localparam logic [APB_TO_W-1:0] TO_LAST = TIMEOUT - APB_TO_W'(1);

  apb_state_e          state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_grant_q, last_grant_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         paddr_q, paddr_d;
  logic [3:0]          pstrb_q, pstrb_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [APB_TO_W-1:0] cnt_q, cnt_d;

  logic pick_gnt, pick_valid;
  logic resp0, resp1;
  logic unused_penable;

  // Upstream penable carries no information for arbitration; psel alone is the request.
  assign unused_penable = m0_penable ^ m1_penable;

  rr_arb2 u_pick (
    .req        ({m1_psel, m0_psel}),
    .last_grant (last_grant_q),
    .gnt        (pick_gnt),
    .gnt_valid  (pick_valid)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_M0;
      last_grant_q <= GNT_M1;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pstrb_q      <= '0;
      pwdata_q     <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pstrb_q      <= pstrb_d;
      pwdata_q     <= pwdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pstrb_d      = pstrb_q;
    pwdata_d     = pwdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = SETUP;
          gnt_d    = pick_gnt;
          pwrite_d = (pick_gnt == GNT_M1) ? m1_pwrite : m0_pwrite;
          paddr_d  = (pick_gnt == GNT_M1) ? m1_paddr  : m0_paddr;
          pstrb_d  = (pick_gnt == GNT_M1) ? m1_pstrb  : m0_pstrb;
          pwdata_d = (pick_gnt == GNT_M1) ? m1_pwdata : m0_pwdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        // A slave answering in the final allowed cycle still wins over the timeout.
        if (pready) begin
          state_d = RESP;
          rdata_d = prdata;
          err_d   = pslverr;
        end else if ((TIMEOUT != '0) && (cnt_q == TO_LAST)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + APB_TO_W'(1);
        end
      end
      RESP: begin
        state_d      = IDLE;
        last_grant_d = gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel       = (state_q == SETUP) || (state_q == ACCESS);
    penable    = (state_q == ACCESS);
    pwrite     = pwrite_q;
    paddr      = paddr_q;
    pstrb      = pstrb_q;
    pwdata     = pwdata_q;
    resp0      = (state_q == RESP) && (gnt_q == GNT_M0);
    resp1      = (state_q == RESP) && (gnt_q == GNT_M1);
    m0_pready  = resp0;
    m0_pslverr = resp0 && err_q;
    m0_prdata  = resp0 ? rdata_q : '0;
    m1_pready  = resp1;
    m1_pslverr = resp1 && err_q;
    m1_prdata  = resp1 ? rdata_q : '0;
  end

endmodule
